memory_read_pipe: RTL and testbench

MEMORY_READ_PIPE -- requirements
Module: memory_read_pipe

---
 rtl/memory_read_pipe.sv | 65 ++++++
 tb/tb_memory_read_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/memory_read_pipe.sv
// Backing word memory for the cache fill path. Single request port; writes
// commit immediately, reads return after a fixed LATENCY-cycle pipeline.
module memory_read_pipe #(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  logic [15:0]           mem [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_req;
  logic                  wr_req;

  logic [LATENCY-1:0]    pipe_vld;
  logic [15:0]           pipe_dat [LATENCY];

  // Word index from the byte address; addr[0] and upper bits are dropped so addresses alias.
  always_comb begin
    idx    = addr[DEPTH_LOG2:1];
    rd_req = enable & ~wr;
    wr_req = enable & wr;
  end

  // Storage: not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_req) begin
      mem[idx] <= data_in;
    end
  end

  // Return pipeline: stage 0 samples storage on the request edge, all stages advance every cycle.
  // The read sees pre-edge contents, so a later write cannot change a word already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_req;
      pipe_dat[0] <= rd_req ? mem[idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  // Output stage: data is forced to zero whenever no read word is returning.
  always_comb begin
    data_valid = pipe_vld[LATENCY-1];
    data_out   = pipe_vld[LATENCY-1] ? pipe_dat[LATENCY-1] : '0;
  end

endmodule

// File: tb/tb_memory_read_pipe.sv
// Scoreboard bench for memory_read_pipe: stimulus pushes expected read words
// with their due cycle; an independent monitor checks every cycle's output.
module tb_memory_read_pipe;

  localparam int unsigned DEPTH_LOG2 = 11;
  localparam int unsigned LATENCY    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  int          due_q[$];

  memory_read_pipe #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LATENCY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_valid", {31'b0, data_valid}, 32'd0);
        chk("reset_data", {16'b0, data_out}, 32'd0);
      end else if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {16'b0, data_out}, 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          int          d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("read_data", {16'b0, data_out}, {16'b0, e});
          chk("read_latency", cyc, d);
        end
      end else begin
        chk("idle_data_zero", {16'b0, data_out}, 32'd0);
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          logic [15:0] e;
          int          d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("missing_return", 32'd0, {16'b0, e});
        end
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; addr = a; data_in = d;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] e);
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = a; data_in = '0;
    exp_q.push_back(e);
    due_q.push_back(cyc + int'(LATENCY));
  endtask

  task automatic do_read_unchecked(input logic [15:0] a);
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = a; data_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    idle(1);
    while (exp_q.size() != 0 && budget < 50) begin
      idle(1);
      budget++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      due_q.delete();
    end
    idle(2);
  endtask

  initial begin
    // Reset held for a few cycles with a request asserted; it must be ignored.
    enable = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'hDEAD;
    repeat (3) @(negedge clk);
    enable = 1'b0; wr = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Write then read next cycle.
    do_write(16'h0010, 16'h1234);
    do_read (16'h0010, 16'h1234);
    drain();

    // Four back-to-back reads.
    do_write(16'h0020, 16'h00A0);
    do_write(16'h0022, 16'h00A1);
    do_write(16'h0024, 16'h00A2);
    do_write(16'h0026, 16'h00A3);
    do_read (16'h0020, 16'h00A0);
    do_read (16'h0022, 16'h00A1);
    do_read (16'h0024, 16'h00A2);
    do_read (16'h0026, 16'h00A3);
    drain();

    // Write after an in-flight read must not alter it.
    do_write(16'h0030, 16'h5555);
    idle(1);
    do_read (16'h0030, 16'h5555);
    do_write(16'h0030, 16'hAAAA);
    do_read (16'h0030, 16'hAAAA);
    drain();

    // Odd address and upper-bit aliasing.
    do_write(16'h0041, 16'hBEEF);
    do_read (16'h0040, 16'hBEEF);
    do_read (16'h1040, 16'hBEEF);
    do_read (16'h0041, 16'hBEEF);
    drain();

    // Read, write, read: valid, bubble, valid.
    do_write(16'h0050, 16'h0F0F);
    do_write(16'h0052, 16'hF0F0);
    do_read (16'h0050, 16'h0F0F);
    do_write(16'h0054, 16'h1111);
    do_read (16'h0052, 16'hF0F0);
    do_read (16'h0054, 16'h1111);
    drain();

    // Reset mid-flight discards two reads; storage survives.
    do_read_unchecked(16'h0020);
    do_read_unchecked(16'h0022);
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = 16'h0024;
    rst_n = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    idle(6);
    do_read (16'h0010, 16'h1234);
    do_read (16'h0026, 16'h00A3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
